// File: rtl/disp_pkg.sv
// Shared types and constants for the seven-segment display arbiter.
// Segment order is {g,f,e,d,c,b,a}, active-low; anodes are active-low.
package disp_pkg;

    localparam int NUM_REQ   = 3;
    localparam int REQ_ALARM = 0;
    localparam int REQ_DIR   = 1;
    localparam int REQ_STAT  = 2;

    typedef enum logic [1:0] {
        IDLE,
        SHOW,
        OPEN
    } state_t;

    localparam logic [NUM_REQ-1:0] GRANT_NONE  = 3'b000;
    localparam logic [NUM_REQ-1:0] GRANT_ALARM = 3'b001;
    localparam logic [NUM_REQ-1:0] GRANT_DIR   = 3'b010;
    localparam logic [NUM_REQ-1:0] GRANT_STAT  = 3'b100;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [3:0] AN_OFF    = 4'b1111;
    localparam logic [3:0] AN_DIG0   = 4'b1110;
    localparam logic [3:0] AN_DIG1   = 4'b1101;
    localparam logic [3:0] AN_DIG2   = 4'b1011;
    localparam logic [3:0] AN_DIG3   = 4'b0111;

    // Glyphs the requesters use to build their four-digit patterns.
    localparam logic [6:0] GLYPH_0    = 7'b1000000;
    localparam logic [6:0] GLYPH_1    = 7'b1111001;
    localparam logic [6:0] GLYPH_2    = 7'b0100100;
    localparam logic [6:0] GLYPH_3    = 7'b0110000;
    localparam logic [6:0] GLYPH_A    = 7'b0001000;
    localparam logic [6:0] GLYPH_E    = 7'b0000110;
    localparam logic [6:0] GLYPH_F    = 7'b0001110;
    localparam logic [6:0] GLYPH_L    = 7'b1000111;
    localparam logic [6:0] GLYPH_R    = 7'b0101111;
    localparam logic [6:0] GLYPH_DASH = 7'b0111111;

    // Isolates the lowest set request bit, giving a one-hot fixed-priority winner.
    function automatic logic [NUM_REQ-1:0] lowestReq(input logic [NUM_REQ-1:0] r);
        return r & (~r + NUM_REQ'(1));
    endfunction

endpackage

// File: rtl/disp_scan.sv
// Digit scanner: free-running scan counter, per-slot blanking and registered seg/an.
module disp_scan
    import disp_pkg::*;
#(
    parameter int SCAN_BITS    = 19,
    parameter int BLANK_CYCLES = 1024
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [27:0] pattern,
    input  logic        valid,
    output logic [6:0]  seg,
    output logic [3:0]  an
);

    localparam int SLOT_BITS = SCAN_BITS - 2;
    localparam logic [SLOT_BITS-1:0] BLANK_LIM = SLOT_BITS'(BLANK_CYCLES);

    logic [SCAN_BITS-1:0] scanCnt;
    logic [1:0]           digit;
    logic [SLOT_BITS-1:0] slotPos;
    logic                 blank;
    logic [6:0]           digitSeg;
    logic [3:0]           digitAn;

    assign digit   = scanCnt[SCAN_BITS-1 -: 2];
    assign slotPos = scanCnt[SLOT_BITS-1:0];
    assign blank   = !valid || (slotPos < BLANK_LIM);

    always_comb begin
        digitSeg = SEG_BLANK;
        digitAn  = AN_OFF;
        case (digit)
            2'd0: begin digitSeg = pattern[6:0];   digitAn = AN_DIG0; end
            2'd1: begin digitSeg = pattern[13:7];  digitAn = AN_DIG1; end
            2'd2: begin digitSeg = pattern[20:14]; digitAn = AN_DIG2; end
            default: begin digitSeg = pattern[27:21]; digitAn = AN_DIG3; end
        endcase
    end

    // Leading blank cycles of every slot suppress ghosting while anodes switch.
    always_ff @(posedge clock) begin
        if (reset) begin
            scanCnt <= '0;
            seg     <= SEG_BLANK;
            an      <= AN_OFF;
        end else begin
            scanCnt <= scanCnt + SCAN_BITS'(1);
            seg     <= blank ? SEG_BLANK : digitSeg;
            an      <= blank ? AN_OFF : digitAn;
        end
    end

endmodule

// File: rtl/disp_arbiter.sv
// Fixed-priority owner of the 4-digit display with minimum hold and alarm preemption.
// Optional macro DISP_BLINK_EN makes the alarm pattern flash.
module disp_arbiter
    import disp_pkg::*;
#(
    parameter int SCAN_BITS    = 19,
    parameter int BLANK_CYCLES = 1024,
    parameter int HOLD_CYCLES  = 50000000,
    parameter int BLINK_BITS   = 26
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    input  logic [27:0]        pat0,
    input  logic [27:0]        pat1,
    input  logic [27:0]        pat2,
    output logic [NUM_REQ-1:0] grant,
    output logic [6:0]         seg,
    output logic [3:0]         an
);

    localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);

    state_t             state;
    logic [HOLD_W-1:0]  holdCnt;
    logic [NUM_REQ-1:0] winner;
    logic [27:0]        activePat;
    logic               blinkOn;
    logic               scanValid;

    assign winner = lowestReq(req);

    // The owner's own request is ignored in SHOW so a glimpse lasts the full hold.
    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            grant   <= GRANT_NONE;
            holdCnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req) begin
                        grant   <= winner;
                        holdCnt <= HOLD_LOAD;
                        state   <= SHOW;
                    end
                end
                SHOW: begin
                    if (req[REQ_ALARM] && (grant != GRANT_ALARM)) begin
                        grant   <= GRANT_ALARM;
                        holdCnt <= HOLD_LOAD;
                    end else if (holdCnt == '0) begin
                        state <= OPEN;
                    end else begin
                        holdCnt <= holdCnt - HOLD_W'(1);
                    end
                end
                OPEN: begin
                    if (!(|req)) begin
                        grant <= GRANT_NONE;
                        state <= IDLE;
                    end else if (winner != grant) begin
                        grant   <= winner;
                        holdCnt <= HOLD_LOAD;
                        state   <= SHOW;
                    end
                end
                default: begin
                    grant <= GRANT_NONE;
                    state <= IDLE;
                end
            endcase
        end
    end

    // Live pattern of the owner, so direction changes show without re-arbitration.
    always_comb begin
        activePat = '0;
        case (grant)
            GRANT_ALARM: activePat = pat0;
            GRANT_DIR:   activePat = pat1;
            GRANT_STAT:  activePat = pat2;
            default:     activePat = '0;
        endcase
    end

`ifdef DISP_BLINK_EN
    logic [BLINK_BITS-1:0] blinkCnt;

    always_ff @(posedge clock) begin
        if (reset) begin
            blinkCnt <= '0;
        end else begin
            blinkCnt <= blinkCnt + BLINK_BITS'(1);
        end
    end

    assign blinkOn = (grant == GRANT_ALARM) && blinkCnt[BLINK_BITS-1];
`else
    // Steady alarm; BLINK_BITS has no role in this build.
    assign blinkOn = 1'b0 && (BLINK_BITS > 0);
`endif

    assign scanValid = (grant != GRANT_NONE) && !blinkOn;

    disp_scan #(
        .SCAN_BITS    (SCAN_BITS),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) u_scan (
        .clock   (clock),
        .reset   (reset),
        .pattern (activePat),
        .valid   (scanValid),
        .seg     (seg),
        .an      (an)
    );

endmodule

// File: tb/tb_disp_arbiter.sv
// Directed self-checking bench for disp_arbiter with a small scan/blink reference model.
module tb_disp_arbiter;
    import disp_pkg::*;

    localparam int SB = 6;
    localparam int BC = 2;
    localparam int HC = 10;
    localparam int BB = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  req   = 3'b000;
    logic [27:0] pat0, pat1, pat2;
    logic [2:0]  grant;
    logic [6:0]  seg;
    logic [3:0]  an;

    int errors = 0;
    int checks = 0;

    disp_arbiter #(
        .SCAN_BITS    (SB),
        .BLANK_CYCLES (BC),
        .HOLD_CYCLES  (HC),
        .BLINK_BITS   (BB)
    ) dut (
        .clock (clock),
        .reset (reset),
        .req   (req),
        .pat0  (pat0),
        .pat1  (pat1),
        .pat2  (pat2),
        .grant (grant),
        .seg   (seg),
        .an    (an)
    );

    always #5 clock = ~clock;

    // mOut is the scan value that the most recent edge turned into seg/an.
    logic [5:0] mScan, mOut;
    logic [3:0] mBlink, mBlinkOut;
    logic       blinkPhase;

    always @(posedge clock) begin
        if (reset) begin
            mScan     <= 6'd0;
            mOut      <= 6'd0;
            mBlink    <= 4'd0;
            mBlinkOut <= 4'd0;
        end else begin
            mOut      <= mScan;
            mScan     <= mScan + 6'd1;
            mBlinkOut <= mBlink;
            mBlink    <= mBlink + 4'd1;
        end
    end

`ifdef DISP_BLINK_EN
    assign blinkPhase = mBlinkOut[3];
`else
    assign blinkPhase = 1'b0;
`endif

    function automatic logic modelBlank(input logic alarm);
        return (mOut[3:0] < 4'd2) || (alarm && blinkPhase);
    endfunction

    function automatic logic [3:0] expAn(input logic alarm);
        if (modelBlank(alarm)) return 4'b1111;
        case (mOut[5:4])
            2'd0:    return 4'b1110;
            2'd1:    return 4'b1101;
            2'd2:    return 4'b1011;
            default: return 4'b0111;
        endcase
    endfunction

    function automatic logic [6:0] expSeg(input logic [27:0] p, input logic alarm);
        if (modelBlank(alarm)) return 7'b1111111;
        return p[mOut[5:4]*7 +: 7];
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic applyStimulus(input logic [2:0] r);
        req = r;
    endtask

    task automatic checkOutput(input string tag, input logic [27:0] obs, input logic [27:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        int bad, badSeg, dig0Bad, cnt0, cnt1, cnt2, cnt3, cntOff, blinkOff;

        pat0 = 28'h1234567;
        pat1 = 28'h0FFFF83;
        pat2 = 28'h5A5A5A5;

        // Reset held three cycles, then idle with no requests.
        tick(3);
        checkOutput("reset_grant", grant, 3'b000);
        checkOutput("reset_an", an, 4'b1111);
        checkOutput("reset_seg", seg, 7'b1111111);
        reset = 1'b0;
        bad = 0;
        repeat (200) begin
            tick(1);
            if (grant !== 3'b000 || an !== 4'b1111 || seg !== 7'b1111111) bad++;
        end
        checkOutput("idle_blank", bad, 0);

        // Direction request and one full scan frame.
        applyStimulus(3'b010);
        tick(1);
        checkOutput("grant_dir", grant, 3'b010);
        tick(1);
        bad = 0; badSeg = 0; dig0Bad = 0;
        cnt0 = 0; cnt1 = 0; cnt2 = 0; cnt3 = 0; cntOff = 0;
        for (int i = 0; i < 64; i++) begin
            if (an !== expAn(1'b0)) bad++;
            if (seg !== expSeg(pat1, 1'b0)) badSeg++;
            case (an)
                4'b1110: begin cnt0++; if (seg !== 7'b0000011) dig0Bad++; end
                4'b1101: cnt1++;
                4'b1011: cnt2++;
                4'b0111: cnt3++;
                4'b1111: cntOff++;
                default: bad++;
            endcase
            tick(1);
        end
        checkOutput("frame_an", bad, 0);
        checkOutput("frame_seg", badSeg, 0);
        checkOutput("dig0_seg", dig0Bad, 0);
        checkOutput("cnt_dig0", cnt0, 14);
        checkOutput("cnt_dig1", cnt1, 14);
        checkOutput("cnt_dig2", cnt2, 14);
        checkOutput("cnt_dig3", cnt3, 14);
        checkOutput("cnt_blank", cntOff, 8);

        applyStimulus(3'b000);
        tick(1);
        checkOutput("open_release", grant, 3'b000);
        tick(1);
        checkOutput("release_blank_an", an, 4'b1111);

        // Status owner preempted by the alarm on its fourth hold cycle.
        applyStimulus(3'b100);
        tick(1);
        checkOutput("grant_stat", grant, 3'b100);
        tick(3);
        applyStimulus(3'b011);
        tick(1);
        checkOutput("preempt", grant, 3'b001);
        applyStimulus(3'b010);
        bad = 0;
        repeat (10) begin
            tick(1);
            if (grant !== 3'b001) bad++;
        end
        checkOutput("alarm_hold_reload", bad, 0);
        tick(1);
        checkOutput("dir_after_open", grant, 3'b010);

        // Owner drops its request early; the hold still runs out.
        tick(2);
        applyStimulus(3'b000);
        bad = 0;
        repeat (8) begin
            tick(1);
            if (grant !== 3'b010) bad++;
        end
        checkOutput("min_hold", bad, 0);
        tick(1);
        checkOutput("drop_to_idle", grant, 3'b000);

        // Two requests in IDLE, held past the hold into OPEN.
        applyStimulus(3'b110);
        tick(1);
        checkOutput("multi_req_low", grant, 3'b010);
        bad = 0;
        repeat (30) begin
            tick(1);
            if (grant !== 3'b010) bad++;
        end
        checkOutput("open_keep", bad, 0);
        applyStimulus(3'b100);
        tick(1);
        checkOutput("open_handover", grant, 3'b100);

        // Alarm preempts, then reset lands mid-SHOW.
        applyStimulus(3'b101);
        tick(1);
        checkOutput("preempt_stat", grant, 3'b001);
        tick(3);
        reset = 1'b1;
        tick(1);
        checkOutput("midreset_grant", grant, 3'b000);
        checkOutput("midreset_an", an, 4'b1111);
        checkOutput("midreset_seg", seg, 7'b1111111);
        tick(1);
        reset = 1'b0;
        tick(1);
        checkOutput("post_reset_alarm", grant, 3'b001);
        tick(1);
        bad = 0; badSeg = 0; cntOff = 0; blinkOff = 0;
        for (int i = 0; i < 64; i++) begin
            if (an !== expAn(1'b1)) bad++;
            if (seg !== expSeg(pat0, 1'b1)) badSeg++;
            if (an === 4'b1111) cntOff++;
            if (an === 4'b1111 && mBlinkOut[3]) blinkOff++;
            tick(1);
        end
        checkOutput("alarm_frame_an", bad, 0);
        checkOutput("alarm_frame_seg", badSeg, 0);
`ifdef DISP_BLINK_EN
        checkOutput("alarm_blink_off", blinkOff, 32);
`else
        checkOutput("alarm_steady_blank", cntOff, 8);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/disp_arbiter.md
Name: disp_arbiter

Overview:
- Shares the 4-digit seven-segment display between three requesters: overcurrent alarm (0, highest), drive direction (1), status (2).
- Fixed-priority arbitration with a minimum hold time; the alarm always preempts.
- Also owns digit scanning with inter-digit blanking, so requesters only supply four-digit patterns.
- Sits between the sensor/direction logic and the board seg/an pins, and replaces the free-running scan mux.

Parameters:
- SCAN_BITS, 19: width of the free-running scan counter; the top 2 bits select the digit.
- BLANK_CYCLES, 1024: clocks at the start of each digit slot with all anodes off. Must be < 2^(SCAN_BITS-2).
- HOLD_CYCLES, 50000000: minimum clocks a grant is held (0.5 s at 100 MHz). Must be ≥ 1.
- BLINK_BITS, 26: blink counter width; its MSB is the blink phase. Used only with DISP_BLINK_EN.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- req  in  3  request per source; bit 0 = alarm
- pat0  in  28  alarm pattern {dig3,dig2,dig1,dig0}, 7 bits per digit, active-low segments
- pat1  in  28  direction pattern
- pat2  in  28  status pattern
- grant  out  3  one-hot current owner; 000 = none
- seg  out  7  active-low segments, registered
- an  out  4  active-low anodes, registered

Behaviour:
- Reset values: grant=000, seg=7'b1111111, an=4'b1111, state=IDLE, scan/hold/blink counters=0.
- Priority: h = lowest index with req set.
- IDLE:
  - If any req: grant h, hold_cnt=HOLD_CYCLES-1, go to SHOW (grant visible the next cycle).
  - Otherwise display blank.
- SHOW:
  - hold_cnt decrements each cycle.
  - If req[0]=1 and grant≠001: grant 001, reload hold_cnt, stay in SHOW (preemption).
  - When hold_cnt==0 and no preemption: go to OPEN.
  - A drop of the owner's req is ignored during SHOW (minimum hold).
- OPEN:
  - No req: grant=000, go to IDLE.
  - h≠owner: grant h, reload hold_cnt, go to SHOW.
  - h==owner: stay.
- Pattern source: live (not latched) pattern of the granted source, so direction changes appear immediately.
- Scan:
  - digit d = scan_cnt[SCAN_BITS-1:SCAN_BITS-2]; counter wraps naturally.
  - an one-cold: d0=1110, d1=1101, d2=1011, d3=0111.
  - seg = pattern[7d+6:7d].
- Blanking: when scan_cnt[SCAN_BITS-3:0] < BLANK_CYCLES, an=1111 and seg=1111111. Same when grant=000.
- Latency:
  - req → grant: 1 cycle.
  - grant/scan → seg/an: 1 cycle (registered outputs).
- Simultaneous events:
  - req[0] rising on the same cycle hold_cnt hits 0: grant 001, reload, stay in SHOW.
  - Multiple reqs in IDLE: lowest index wins.
- Reset mid-operation: all state returns to reset values on the next edge; no partial frame is held.

Optional Feature:
- Macro DISP_BLINK_EN.
- Defined: free-running BLINK_BITS counter; while grant==001 and blink MSB=1, forces an=1111 and seg=1111111 (alarm flashes).
- Undefined: no blink counter; alarm shown steady; BLINK_BITS is unused.

Decomposition:
- Package disp_pkg:
  - NUM_REQ=3, REQ_ALARM/REQ_DIR/REQ_STAT indices.
  - State enum {IDLE, SHOW, OPEN}.
  - SEG_BLANK=7'b1111111, AN_OFF=4'b1111, per-digit anode constants.
  - Glyph constants used by requesters.
- Sub-module disp_scan: scan counter, digit select, blanking, seg/an output registers; input is a 28-bit pattern plus a valid bit.

Test Plan (SCAN_BITS=6, BLANK_CYCLES=2, HOLD_CYCLES=10):
- Reset held 3 cycles then released with req=000 → grant=000, an=1111, seg=1111111 for 200 cycles.
- req=010, pat1=28'h0FFFF83 → grant=010 one cycle later. Over one 64-cycle frame, each anode is active for 14 cycles after 2 blank cycles; an=1110 shows seg=0000011.
- Owner 100, req[0] asserted at hold cycle 4 → grant=001 next cycle; hold reloads to 10; a req=010 arriving at the same time waits until OPEN.
- Grant 010, req drops at hold cycle 3 → grant stays 010 through cycle 10, then 000 and IDLE one cycle after OPEN.
- req=110 continuous → grant 010 held indefinitely in OPEN; req1 drops → grant=100 on the next cycle.
- Reset asserted during SHOW with grant=001 → next edge grant=000, an=1111. With DISP_BLINK_EN and BLINK_BITS=4: alarm anodes are all off for 8 of every 16 cycles.
